mbox_tx_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one mailbox write channel among N local requesters.
- Grants the channel for a whole packet, forwards words with the valid/ready handshake, and signals end-of-packet with `mbox_w_done`.
- Runs the abort handshake in both directions: abort initiated by the local owner, and abort initiated by the remote side.
- Sits between on-chip message producers and the write side of the `mbox_apb` mailbox, in the `aclk` domain.

---
 rtl/mbox_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_mbox_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbox_tx_arbiter.sv
// mbox_tx_arbiter: round-robin packet arbiter onto one mailbox write channel; MBOX_ARB_LENCHK_EN adds an overlength check
module mbox_tx_arbiter #(
    parameter int N      = 4,
    parameter int MAXLEN = 1024,
    localparam int GW    = $clog2(N)
) (
    input  logic            aclk,
    input  logic            resetn,
    input  logic [N*32-1:0] req_dat,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_last,
    output logic [N-1:0]    req_ready,
    input  logic [N-1:0]    req_abort,
    output logic [N-1:0]    req_done,
    output logic [N-1:0]    req_aborted,
    output logic [31:0]     mbox_w_dat,
    output logic            mbox_w_valid,
    input  logic            mbox_w_ready,
    output logic            mbox_w_done,
    output logic            mbox_w_abort,
    input  logic            mbox_r_abort,
    output logic            busy,
    output logic [GW-1:0]   gnt_id,
    output logic            len_err
);
    typedef enum logic [2:0] {IDLE, SEND, DONE, ABORT_INIT, ABORT_ACK} state_e;

    state_e        state_q, state_d;
    logic [GW-1:0] ptr_q, ptr_d, gnt_q, gnt_d, win, idx;
    logic          found, send, hs, own_last, own_abort;

`ifdef MBOX_ARB_LENCHK_EN
    localparam int CW = $clog2(MAXLEN + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          len_err_q, len_err_d;
`endif

    assign send      = state_q == SEND;
    assign own_last  = req_last[gnt_q];
    assign own_abort = req_abort[gnt_q];
    assign hs        = send & req_valid[gnt_q] & mbox_w_ready;

    // first requesting index at or after ptr, wrapping modulo N
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = GW'((int'(ptr_q) + k) % N);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef MBOX_ARB_LENCHK_EN
    always_ff @(posedge aclk) begin
        if (!resetn) begin
            cnt_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            len_err_q <= len_err_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
`ifdef MBOX_ARB_LENCHK_EN
        cnt_d     = cnt_q;
        len_err_d = len_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (mbox_r_abort) begin
                    state_d = ABORT_ACK;
                end else if (found) begin
                    gnt_d   = win;
                    ptr_d   = (win == GW'(N - 1)) ? '0 : win + 1'b1;
                    state_d = SEND;
`ifdef MBOX_ARB_LENCHK_EN
                    cnt_d   = '0;
`endif
                end
            end
            SEND: begin
                // a remote abort wins even over a last handshake; a local abort loses to it
                if (mbox_r_abort) begin
                    state_d = ABORT_ACK;
                end else if (own_abort && !(hs && own_last)) begin
                    state_d = ABORT_INIT;
                end else if (hs && own_last) begin
                    state_d = DONE;
`ifdef MBOX_ARB_LENCHK_EN
                end else if (hs) begin
                    if (cnt_q == CW'(MAXLEN - 1)) begin
                        len_err_d = 1'b1;
                        state_d   = ABORT_INIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`endif
                end
            end
            DONE:       state_d = IDLE;
            ABORT_INIT: state_d = mbox_r_abort ? IDLE : ABORT_INIT;
            ABORT_ACK:  state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready              = '0;
        req_done               = '0;
        req_aborted            = '0;
        req_ready[gnt_q]       = send & mbox_w_ready;
        req_done[gnt_q]        = state_q == DONE;
        req_aborted[gnt_q]     = (send || state_q == ABORT_INIT) && mbox_r_abort;
    end

    assign mbox_w_dat   = send ? req_dat[32*int'(gnt_q) +: 32] : '0;
    assign mbox_w_valid = send & req_valid[gnt_q];
    assign mbox_w_done  = state_q == DONE;
    assign mbox_w_abort = state_q == ABORT_INIT || state_q == ABORT_ACK;
    assign busy         = state_q != IDLE;
    assign gnt_id       = gnt_q;

`ifdef MBOX_ARB_LENCHK_EN
    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif
endmodule

// File: tb/tb_mbox_tx_arbiter.sv
// tb_mbox_tx_arbiter: directed and randomized checks of mbox_tx_arbiter against a packet-level model (MBOX_ARB_LENCHK_EN selects the overlength case)
module tb_mbox_tx_arbiter;
    localparam int N = 4;
    localparam logic [N-1:0] NA = '0;

    logic            aclk = 1'b0;
    logic            resetn = 1'b0;
    logic [N*32-1:0] req_dat;
    logic [N-1:0]    req_valid, req_last, req_ready, req_abort, req_done, req_aborted;
    logic [31:0]     mbox_w_dat;
    logic            mbox_w_valid, mbox_w_ready, mbox_w_done, mbox_w_abort, mbox_r_abort, busy, len_err;
    logic [1:0]      gnt_id;

    int passed = 0, total = 0, cycnt = 0, pending = 0, mptr = 0;
    logic [32:0] q[N][$];
    logic [31:0] mq[N][$];
    int          pl[N][$];
    int          done_t[$];

    always #5 aclk = ~aclk;

    mbox_tx_arbiter #(.N(N), .MAXLEN(8)) dut (
        .aclk(aclk), .resetn(resetn), .req_dat(req_dat), .req_valid(req_valid),
        .req_last(req_last), .req_ready(req_ready), .req_abort(req_abort),
        .req_done(req_done), .req_aborted(req_aborted), .mbox_w_dat(mbox_w_dat),
        .mbox_w_valid(mbox_w_valid), .mbox_w_ready(mbox_w_ready), .mbox_w_done(mbox_w_done),
        .mbox_w_abort(mbox_w_abort), .mbox_r_abort(mbox_r_abort), .busy(busy),
        .gnt_id(gnt_id), .len_err(len_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic drive();
        logic [32:0] e;
        for (int i = 0; i < N; i++) begin
            e = '0;
            if (q[i].size() > 0) e = q[i][0];
            req_valid[i]         = q[i].size() > 0;
            req_last[i]          = e[32];
            req_dat[i*32 +: 32]  = e[31:0];
        end
    endtask

    task automatic tick(input logic rdy, input logic rab, input logic [N-1:0] ab);
        logic [N-1:0] hs;
        hs = req_valid & req_ready;
        @(posedge aclk);
        #1;
        cycnt++;
        for (int i = 0; i < N; i++) if (hs[i] && q[i].size() > 0) void'(q[i].pop_front());
        mbox_w_ready = rdy;
        mbox_r_abort = rab;
        req_abort    = ab;
        drive();
        #1;
    endtask

    task automatic add_pkt(input int i, input int len);
        logic [31:0] d;
        logic        l;
        for (int w = 0; w < len; w++) begin
            d = $urandom;
            l = (w == len - 1);
            q[i].push_back({l, d});
            mq[i].push_back(d);
        end
        pl[i].push_back(len);
        pending++;
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++)
            if (pl[(mptr + k) % N].size() > 0) return (mptr + k) % N;
        return 0;
    endfunction

    // packet-level model: next owner is the first pending requester after the last one served
    task automatic run_model(input int budget, input bit rnd);
        int cur = -1, got = 0, cyc = 0;
        while (pending > 0 && cyc < budget) begin
            if (mbox_w_valid && mbox_w_ready) begin
                if (cur < 0) begin cur = pick(); got = 0; end
                chk("owner", 32'(gnt_id), cur);
                chk("ready_onehot", 32'(req_ready), 1 << cur);
                if (mq[cur].size() > 0) chk("word", mbox_w_dat, mq[cur].pop_front());
                got++;
            end
            if (mbox_w_done) begin
                if (cur < 0) begin cur = pick(); got = 0; end
                chk("done_vec", 32'(req_done), 1 << cur);
                chk("pkt_len", got, pl[cur][0]);
                void'(pl[cur].pop_front());
                pending--;
                mptr = (cur + 1) % N;
                cur = -1;
                done_t.push_back(cycnt);
            end
            tick(rnd ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, NA);
            cyc++;
        end
        chk("drain_pending", pending, 0);
    endtask

    initial begin
        bit pat[6] = '{1, 0, 0, 1, 1, 1};
        int bi, ol;
        mbox_w_ready = 1'b0; mbox_r_abort = 1'b0; req_abort = NA;
        drive();
        tick(1'b0, 1'b0, NA);
        tick(1'b0, 1'b0, NA);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt", 32'(gnt_id), 0);
        chk("rst_wvalid", 32'(mbox_w_valid), 0);
        chk("rst_wdat", mbox_w_dat, 0);
        chk("rst_wdone", 32'(mbox_w_done), 0);
        chk("rst_wabort", 32'(mbox_w_abort), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_done", 32'(req_done), 0);
        chk("rst_aborted", 32'(req_aborted), 0);
        chk("rst_len_err", 32'(len_err), 0);
        // round robin: 0,2,3 pending from reset, then 0 and 2 again
        add_pkt(0, 3); add_pkt(2, 3); add_pkt(3, 3);
        tick(1'b1, 1'b0, NA);
        chk("rr_held_in_reset", 32'(busy), 0);
        resetn = 1'b1;
        done_t.delete();
        run_model(100, 1'b0);
        chk("rr_done_count", done_t.size(), 3);
        if (done_t.size() == 3) begin
            chk("rr_period_a", done_t[1] - done_t[0], 5);
            chk("rr_period_b", done_t[2] - done_t[1], 5);
        end
        add_pkt(0, 2); add_pkt(2, 1);
        drive(); #1;
        run_model(50, 1'b0);
        // single-word packet
        q[1].push_back({1'b1, 32'hDEADBEEF});
        drive(); #1;
        chk("sw_idle", 32'(busy), 0);
        tick(1'b1, 1'b0, NA);
        chk("sw_valid", 32'(mbox_w_valid), 1);
        chk("sw_dat", mbox_w_dat, 32'hDEADBEEF);
        chk("sw_ready", 32'(req_ready), 32'h2);
        chk("sw_gnt", 32'(gnt_id), 1);
        tick(1'b1, 1'b0, NA);
        chk("sw_wdone", 32'(mbox_w_done), 1);
        chk("sw_req_done", 32'(req_done), 32'h2);
        tick(1'b1, 1'b0, NA);
        chk("sw_busy_clear", 32'(busy), 0);
        chk("sw_wdone_clear", 32'(mbox_w_done), 0);
        // local abort after two words, remote side answers five cycles later
        for (int k = 0; k < 4; k++) q[2].push_back({k == 3, 32'hA0 + 32'(k)});
        drive(); #1;
        tick(1'b1, 1'b0, NA);
        chk("la_w0", mbox_w_dat, 32'hA0);
        tick(1'b1, 1'b0, NA);
        chk("la_w1", mbox_w_dat, 32'hA1);
        tick(1'b0, 1'b0, 4'b0100);
        chk("la_send_noabort", 32'(mbox_w_abort), 0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 4'b0100);
            chk("la_hold", 32'(mbox_w_abort), 1);
            chk("la_ready_low", 32'(req_ready), 0);
            chk("la_no_pulse", 32'(req_aborted), 0);
        end
        tick(1'b1, 1'b1, NA);
        chk("la_aborted", 32'(req_aborted), 32'h4);
        chk("la_no_wdone", 32'(mbox_w_done), 0);
        q[2].delete();
        tick(1'b1, 1'b0, NA);
        chk("la_idle", 32'(busy), 0);
        chk("la_abort_clear", 32'(mbox_w_abort), 0);
        // remote abort on the same cycle as the last handshake
        q[3].push_back({1'b0, 32'hB0}); q[3].push_back({1'b1, 32'hB1});
        drive(); #1;
        tick(1'b1, 1'b0, NA);
        chk("ra_w0", mbox_w_dat, 32'hB0);
        tick(1'b1, 1'b1, NA);
        chk("ra_aborted", 32'(req_aborted), 32'h8);
        chk("ra_no_done", 32'(req_done), 0);
        tick(1'b1, 1'b0, NA);
        chk("ra_ack", 32'(mbox_w_abort), 1);
        chk("ra_ack_no_wdone", 32'(mbox_w_done), 0);
        chk("ra_ack_no_done", 32'(req_done), 0);
        tick(1'b1, 1'b0, NA);
        chk("ra_ack_len", 32'(mbox_w_abort), 0);
        chk("ra_idle", 32'(busy), 0);
        // remote abort while idle
        tick(1'b1, 1'b1, NA);
        chk("ri_idle_abort", 32'(mbox_w_abort), 0);
        tick(1'b1, 1'b0, NA);
        chk("ri_ack", 32'(mbox_w_abort), 1);
        chk("ri_no_aborted", 32'(req_aborted), 0);
        chk("ri_no_done", 32'(req_done), 0);
        tick(1'b1, 1'b0, NA);
        chk("ri_ack_len", 32'(mbox_w_abort), 0);
        // backpressure 1,0,0,1 on a 4-word packet
        for (int k = 0; k < 4; k++) q[0].push_back({k == 3, 32'hC0 + 32'(k)});
        drive(); #1;
        bi = 0;
        for (int j = 0; j < 6; j++) begin
            tick(1'(pat[j]), 1'b0, NA);
            chk("bp_ready", 32'(req_ready), pat[j] ? 1 : 0);
            if (mbox_w_valid && mbox_w_ready) begin
                chk("bp_word", mbox_w_dat, 32'hC0 + 32'(bi));
                bi++;
            end
        end
        chk("bp_count", bi, 4);
        tick(1'b1, 1'b0, NA);
        chk("bp_wdone", 32'(mbox_w_done), 1);
        chk("bp_req_done", 32'(req_done), 32'h1);
        tick(1'b1, 1'b0, NA);
        // reset in the middle of a packet
        for (int k = 0; k < 5; k++) q[1].push_back({k == 4, 32'hD0 + 32'(k)});
        drive(); #1;
        tick(1'b1, 1'b0, NA);
        tick(1'b1, 1'b0, NA);
        resetn = 1'b0;
        tick(1'b1, 1'b0, NA);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_gnt", 32'(gnt_id), 0);
        chk("mr_no_done", 32'(req_done), 0);
        chk("mr_no_aborted", 32'(req_aborted), 0);
        chk("mr_wvalid", 32'(mbox_w_valid), 0);
        q[1].delete();
        resetn = 1'b1;
        drive(); #1;
        // 10-word packet against MAXLEN=8
        for (int k = 0; k < 10; k++) q[0].push_back({k == 9, 32'hE0 + 32'(k)});
        drive(); #1;
        ol = 0;
`ifdef MBOX_ARB_LENCHK_EN
        for (int j = 0; j < 8; j++) begin
            tick(1'b1, 1'b0, NA);
            if (mbox_w_valid && mbox_w_ready) ol++;
        end
        chk("ol_accepted", ol, 8);
        tick(1'b1, 1'b0, NA);
        chk("ol_abort", 32'(mbox_w_abort), 1);
        chk("ol_len_err", 32'(len_err), 1);
        chk("ol_ready_low", 32'(req_ready), 0);
        tick(1'b1, 1'b1, NA);
        chk("ol_aborted", 32'(req_aborted), 32'h1);
        q[0].delete();
        tick(1'b1, 1'b0, NA);
        chk("ol_sticky", 32'(len_err), 1);
        chk("ol_idle", 32'(busy), 0);
        resetn = 1'b0;
        tick(1'b1, 1'b0, NA);
        chk("ol_reset_clear", 32'(len_err), 0);
        resetn = 1'b1;
`else
        for (int j = 0; j < 10; j++) begin
            tick(1'b1, 1'b0, NA);
            if (mbox_w_valid && mbox_w_ready) ol++;
        end
        chk("nl_accepted", ol, 10);
        tick(1'b1, 1'b0, NA);
        chk("nl_wdone", 32'(mbox_w_done), 1);
        chk("nl_len_err", 32'(len_err), 0);
        tick(1'b1, 1'b0, NA);
`endif
        // randomized packets with random backpressure, from a fresh reset
        resetn = 1'b0;
        for (int i = 0; i < N; i++) begin q[i].delete(); mq[i].delete(); pl[i].delete(); end
        pending = 0;
        mptr = 0;
        tick(1'b1, 1'b0, NA);
        resetn = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                int n = $urandom_range(0, 3);
                for (int p = 0; p < n; p++) add_pkt(i, $urandom_range(1, 6));
            end
            drive(); #1;
            run_model(2000, 1'b1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
